// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: fixed 34-cycle busy window,
// quotient on lo, remainder on hi, one-cycle done pulse on completion.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             PC_CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] dvs_reg, quo_reg, rem_reg;
    logic             neg_q_reg, neg_r_reg;
    logic             busy_reg, done_reg;
    logic [WIDTH-1:0] lo_reg, hi_reg;

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        a_neg  = sgn_reg & a_reg[WIDTH-1];
        b_neg  = sgn_reg & b_reg[WIDTH-1];
        b_zero = (b_reg == '0);
        a_mag  = a_neg ? -a_reg : a_reg;
        b_mag  = b_neg ? -b_reg : b_reg;
        // The remainder is always below the divisor, so 32 stored bits plus
        // the shifted-in quotient bit form the full 33-bit working value.
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_reg};
        quo_fix = neg_q_reg ? -quo_reg : quo_reg;
        rem_fix = neg_r_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge PC_CLK) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (cnt_reg == LAST_CNT) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PC_CLK) begin
        if (Reset) begin
            cnt_reg   <= '0;
            sgn_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            dvs_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sgn_reg  <= is_signed;
                        a_reg    <= dividend;
                        b_reg    <= divisor;
                        busy_reg <= 1'b1;
                    end
                end
                PREP: begin
                    quo_reg   <= a_mag;
                    dvs_reg   <= b_mag;
                    rem_reg   <= '0;
                    cnt_reg   <= '0;
                    // A zero divisor keeps the all-ones quotient uncorrected;
                    // the remainder still recovers the original dividend.
                    neg_q_reg <= (a_neg ^ b_neg) & ~b_zero;
                    neg_r_reg <= a_neg;
                end
                ITER: begin
                    if (!trial[WIDTH]) begin
                        rem_reg <= trial[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    lo_reg   <= quo_fix;
                    hi_reg   <= rem_fix;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign lo   = lo_reg;
    assign hi   = hi_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against a plain-arithmetic
// MIPS DIV/DIVU reference model.
module tb_div_unit;

    logic        PC_CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] lo, hi;

    int vectors = 0;
    int miscompares = 0;

    always #5 PC_CLK = ~PC_CLK;

    div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .PC_CLK(PC_CLK), .Reset(Reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .lo(lo), .hi(hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncate toward zero, remainder follows the dividend.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge PC_CLK);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles and checks the done cycle; returns at the done-cycle negedge.
    task automatic wait_done(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input bit interfere);
        logic [31:0] eq, er;
        int n = 0;
        bit early_done = 0;
        model(s, a, b, eq, er);
        for (int k = 0; k < 100; k++) begin
            @(negedge PC_CLK);
            if (!busy) break;
            if (done) early_done = 1;
            n++;
            if (interfere && (n == 5 || n == 20)) begin
                start     = 1'b1;
                is_signed = $urandom_range(0, 1);
                dividend  = $urandom;
                divisor   = $urandom_range(1, 50);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_cycles", 32'(n), 32'd34);
        chk("done_while_busy", {31'd0, early_done}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("lo", lo, eq);
        chk("hi", hi, er);
        $display("op s=%0d %h / %h -> lo=%h hi=%h (exp %h %h) busy=%0d", s, a, b, lo, hi, eq, er, n);
    endtask

    task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit interfere);
        logic [31:0] eq, er;
        launch(s, a, b);
        wait_done(s, a, b, interfere);
        model(s, a, b, eq, er);
        @(negedge PC_CLK);
        chk("done_clears", {31'd0, done}, 32'd0);
        chk("lo_hold", lo, eq);
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b;
        Reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge PC_CLK);
        @(negedge PC_CLK);
        Reset = 1'b0;
        repeat (5) @(negedge PC_CLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        op(1'b0, 32'd100, 32'd7, 0);
        op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op(1'b0, 32'h1234_5678, 32'd0, 0);
        op(1'b1, 32'hFFFF_FF00, 32'd0, 0);
        op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

        // Starts pulsed mid-operation must be ignored.
        op(1'b0, 32'd100, 32'd7, 1);

        // Start in the done cycle launches a second operation.
        launch(1'b0, 32'd1000, 32'd33);
        wait_done(1'b0, 32'd1000, 32'd33, 0);
        launch(1'b1, 32'hFFFF_FC18, 32'd33);
        chk("chain_done_clears", {31'd0, done}, 32'd0);
        chk("chain_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b1, 32'hFFFF_FC18, 32'd33, 0);
        @(negedge PC_CLK);

        // Reset mid-operation aborts with no done pulse.
        launch(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge PC_CLK);
        Reset = 1'b1;
        @(posedge PC_CLK);
        #1 Reset = 1'b0;
        @(negedge PC_CLK);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge PC_CLK);
            if (done || busy) begin
                chk("midrst_quiet", {30'd0, busy, done}, 32'd0);
                break;
            end
        end
        op(1'b0, 32'd9, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 255);
                3:       b = -$urandom_range(1, 255);
                default: b = $urandom;
            endcase
            op(s, a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
